// File: rtl/eflags_commit_if.sv
// rtl/eflags_commit_if.sv - execute-to-commit flag update channel
//
// Carries one flag update per handshake from the execute stage.
//   ex_valid : producer presents an update (held with data until accepted)
//   ex_ready : consumer can take the update this cycle
//   ex_flags : packed flag word (OF=11 DF=10 SF=7 ZF=6 AF=4 PF=2 CF=0)
//   ex_mask  : per-flag write enable {OF,DF,SF,ZF,AF,PF,CF}
//   ex_op    : 00/11 masked merge, 01 CMC, 10 full load
interface eflags_commit_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_flags;
    logic [6:0]  ex_mask;
    logic [1:0]  ex_op;

    modport master (
        output ex_valid,
        output ex_flags,
        output ex_mask,
        output ex_op,
        input  ex_ready
    );

    modport slave (
        input  ex_valid,
        input  ex_flags,
        input  ex_mask,
        input  ex_op,
        output ex_ready
    );
endinterface

// File: rtl/eflags_commit.sv
// rtl/eflags_commit.sv - architectural EFLAGS register with one-entry commit buffer
//
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   ex            : update channel (slave side), see eflags_commit_if
//   issue_flag_wr : decode issued a future flag writer (pending +1)
//   wb_stall      : holds the buffered update back from committing
//   flags         : architectural EFLAGS, reserved bits read as 0
//   flags_busy    : at least one flag writer in flight
//   flag_err      : sticky pending-counter overflow/underflow
module eflags_commit #(
    parameter int PEND_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    eflags_commit_if.slave ex,
    input  logic           issue_flag_wr,
    input  logic           wb_stall,
    output logic [31:0]    flags,
    output logic           flags_busy,
    output logic           flag_err
);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_ZERO + 1'b1;

    // Flags are stored compactly in mask order {OF,DF,SF,ZF,AF,PF,CF}, so
    // reserved bits never have storage and cannot be written.
    logic [6:0]        arch;
    logic [6:0]        buf_flags;
    logic [6:0]        buf_mask;
    logic [1:0]        buf_op;
    logic              buf_valid;
    logic [PEND_W-1:0] pending;

    logic              accept;
    logic              commit;
    logic [6:0]        ex_flags7;
    logic [6:0]        arch_next;
    logic [PEND_W-1:0] pend_next;
    logic              err_set;
    logic              unused_bits;

    assign ex_flags7 = {ex.ex_flags[11], ex.ex_flags[10], ex.ex_flags[7],
                        ex.ex_flags[6],  ex.ex_flags[4],  ex.ex_flags[2],
                        ex.ex_flags[0]};
    assign unused_bits = ^{ex.ex_flags[31:12], ex.ex_flags[9:8], ex.ex_flags[5],
                           ex.ex_flags[3], ex.ex_flags[1]};

    // A commit frees the buffer in the same cycle, so a stall-free pipeline
    // sustains one update per clock.
    assign ex.ex_ready = !buf_valid || !wb_stall;
    assign accept      = ex.ex_valid && ex.ex_ready;
    assign commit      = buf_valid && !wb_stall;

    assign flags = {20'b0, arch[6], arch[5], 2'b00, arch[4], arch[3], 1'b0,
                    arch[2], 1'b0, arch[1], 1'b0, arch[0]};

    always_comb begin
        arch_next = arch;
        case (buf_op)
            2'b01:   arch_next = {arch[6:1], ~arch[0]};
            2'b10:   arch_next = buf_flags;
            default: arch_next = (arch & ~buf_mask) | (buf_flags & buf_mask);
        endcase
    end

    // Issue and commit together cancel, even at zero, so that case is not
    // an underflow.
    always_comb begin
        pend_next = pending;
        err_set   = 1'b0;
        if (issue_flag_wr && !commit) begin
            if (pending == PEND_MAX) err_set = 1'b1;
            else                     pend_next = pending + PEND_ONE;
        end else if (commit && !issue_flag_wr) begin
            if (pending == PEND_ZERO) err_set = 1'b1;
            else                      pend_next = pending - PEND_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arch       <= '0;
            buf_flags  <= '0;
            buf_mask   <= '0;
            buf_op     <= '0;
            buf_valid  <= 1'b0;
            pending    <= '0;
            flags_busy <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            if (commit) begin
                arch <= arch_next;
            end
            if (accept) begin
                buf_flags <= ex_flags7;
                buf_mask  <= ex.ex_mask;
                buf_op    <= ex.ex_op;
                buf_valid <= 1'b1;
            end else if (commit) begin
                buf_valid <= 1'b0;
            end
            pending    <= pend_next;
            flags_busy <= (pend_next != PEND_ZERO);
            if (err_set) begin
                flag_err <= 1'b1;
            end
        end
    end
endmodule
